// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: MDMOp codes,
// FSM state encodings and HI/LO address select values.
package mdu_pkg;

    localparam logic [2:0] MDU_MULTU = 3'b000;
    localparam logic [2:0] MDU_MULT  = 3'b001;
    localparam logic [2:0] MDU_DIVU  = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b011;
    localparam logic [2:0] MDU_MTMF  = 3'b100;
    localparam logic [2:0] MDU_MADD  = 3'b101;
    localparam logic [2:0] MDU_MSUB  = 3'b110;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic MDU_ADDR_HI = 1'b0;
    localparam logic MDU_ADDR_LO = 1'b1;

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_DIVU) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage bundle between decoder/forwarding and the mult/div unit.
// master drives the request side, slave is the unit itself.
interface mdu_if;

    logic        MDMStart;
    logic [2:0]  MDMOp;
    logic        MDMWrite;
    logic        MDMAddr;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDMOut;

    modport master (
        output MDMStart, MDMOp, MDMWrite, MDMAddr, A, B,
        input  Busy, HI, LO, MDMOut
    );

    modport slave (
        input  MDMStart, MDMOp, MDMWrite, MDMAddr, A, B,
        output Busy, HI, LO, MDMOut
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational datapath: {A,B,op,HI,LO} -> 64-bit {hi,lo} result
// plus divide-by-zero flag. MADD/MSUB exist only with MDU_MADD_EN.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_res,
    output logic        o_div0
);

    logic [63:0]        w_uprod;
    logic [63:0]        w_sprod;
    logic               w_b_zero;
    logic               w_ovf;
    logic [31:0]        w_ub;
    logic signed [31:0] w_sb;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;

    assign w_uprod = {32'b0, i_a} * {32'b0, i_b};
    assign w_sprod = $signed({{32{i_a[31]}}, i_a})
                   * $signed({{32{i_b[31]}}, i_b});

    assign w_b_zero = (i_b == 32'd0);
    // -2^31 / -1 is rerouted to a divide by 1, which gives the
    // wrapped quotient 0x80000000 and remainder 0 directly.
    assign w_ovf = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
    assign w_ub  = w_b_zero ? 32'd1 : i_b;
    assign w_sb  = (w_b_zero || w_ovf) ? 32'sd1 : $signed(i_b);
    assign w_uq  = i_a / w_ub;
    assign w_ur  = i_a % w_ub;
    assign w_sq  = $signed(i_a) / w_sb;
    assign w_sr  = $signed(i_a) % w_sb;

`ifdef MDU_MADD_EN
    logic [63:0] w_acc_add;
    logic [63:0] w_acc_sub;
    assign w_acc_add = {i_hi, i_lo} + w_sprod;
    assign w_acc_sub = {i_hi, i_lo} - w_sprod;
`else
    logic w_unused_acc;
    assign w_unused_acc = ^{i_hi, i_lo};
`endif

    // Select the 64-bit result for the requested operation
    always_comb begin
        o_res = 64'd0;
        case (i_op)
            MDU_MULTU: o_res = w_uprod;
            MDU_MULT:  o_res = w_sprod;
            MDU_DIVU:  o_res = {w_ur, w_uq};
            MDU_DIV:   o_res = {w_sr, w_sq};
`ifdef MDU_MADD_EN
            MDU_MADD:  o_res = w_acc_add;
            MDU_MSUB:  o_res = w_acc_sub;
`endif
            default:   o_res = 64'd0;
        endcase
    end

    assign o_div0 = is_div(i_op) && w_b_zero;

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO registers and Busy-based latency model.
// Define MDU_MADD_EN to enable MADD (101) and MSUB (110).
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)(
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_res_hi;
    logic [31:0]   r_res_lo;
    logic          r_div0;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    logic [63:0]   w_res;
    logic          w_div0;
    logic          w_op_ok;
    logic          w_idle;
    logic          w_launch;
    logic          w_write;

    mdu_arith u_arith (
        .i_a    (bus.A),
        .i_b    (bus.B),
        .i_op   (bus.MDMOp),
        .i_hi   (r_hi),
        .i_lo   (r_lo),
        .o_res  (w_res),
        .o_div0 (w_div0)
    );

    // Decide which op codes actually launch a multi-cycle operation
    always_comb begin
        w_op_ok = 1'b0;
        case (bus.MDMOp)
            MDU_MULTU, MDU_MULT,
            MDU_DIVU,  MDU_DIV:  w_op_ok = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD,  MDU_MSUB: w_op_ok = 1'b1;
`endif
            default:             w_op_ok = 1'b0;
        endcase
    end

    assign w_idle   = (r_state == IDLE);
    assign w_launch = w_idle && bus.MDMStart && w_op_ok;
    assign w_write  = w_idle && bus.MDMWrite && !bus.MDMStart;

    // FSM: launch latches the result, RUN counts down, commit at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (r_state == IDLE) begin
            if (w_launch) begin
                r_res_hi <= w_res[63:32];
                r_res_lo <= w_res[31:0];
                r_div0   <= w_div0;
                r_cnt    <= is_div(bus.MDMOp) ? CW'(DIV_CYCLES - 1)
                                              : CW'(MULT_CYCLES - 1);
                r_state  <= RUN;
            end else if (w_write) begin
                if (bus.MDMAddr == MDU_ADDR_LO) begin
                    r_lo <= bus.A;
                end else begin
                    r_hi <= bus.A;
                end
            end
        end else begin
            if (r_cnt == '0) begin
                if (!r_div0) begin
                    r_hi <= r_res_hi;
                    r_lo <= r_res_lo;
                end
                r_state <= IDLE;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign bus.Busy   = (r_state == RUN);
    assign bus.HI     = r_hi;
    assign bus.LO     = r_lo;
    assign bus.MDMOut = (bus.MDMAddr == MDU_ADDR_LO) ? r_lo : r_hi;

endmodule
